// File: rtl/vram_rot_fetch_pkg.sv
// Shared frame-buffer geometry, Q2.14 constants and address helper for the ZBT
// read/write rotators.
package vram_pkg;

  localparam int unsigned H_ACTIVE  = 800;
  localparam int unsigned V_ACTIVE  = 600;
  localparam int          FRAC_BITS = 14;
  localparam logic signed [15:0] ONE = 16'sd16384;

  typedef logic [15:0] pixel_t;
  typedef logic [18:0] vaddr_t;

  // y*800 + x built from shifts: 800 = 512 + 256 + 32.
  function automatic vaddr_t row_addr(input logic [9:0] y, input logic [10:0] x);
    vaddr_t yw;
    yw = {9'b0, y};
    return (yw << 9) + (yw << 8) + (yw << 5) + {8'b0, x};
  endfunction

endpackage

// File: rtl/vram_rot_fetch_if.sv
// ZBT read port bundle: address out from the fetcher, read word back from the RAM.
interface vram_rot_fetch_if;
  import vram_pkg::*;

  vaddr_t      vram_addr;
  logic [35:0] vram_read_data;

  modport master (output vram_addr, input vram_read_data);
  modport slave  (input vram_addr, output vram_read_data);

endinterface

// File: rtl/vram_rot_fetch_rot_mac.sv
// Rotation multiply-accumulate: registered Q2.14 products, then rounded,
// re-centred source coordinates (combinational from the product registers).
module rot_mac
  import vram_pkg::*;
#(
  parameter int CX = 400,
  parameter int CY = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] cos_l,
  input  logic signed [15:0] sin_l,
  input  logic signed [11:0] dx,
  input  logic signed [11:0] dy,
  output logic signed [15:0] sx,
  output logic signed [15:0] sy
);

  logic signed [27:0] p_cdx, p_sdy, p_sdx, p_cdy;
  logic signed [28:0] sum_x, sum_y;

  // 28-bit operands keep -16384 * -2048 and friends exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_cdx <= '0;
      p_sdy <= '0;
      p_sdx <= '0;
      p_cdy <= '0;
    end else begin
      p_cdx <= 28'(cos_l) * 28'(dx);
      p_sdy <= 28'(sin_l) * 28'(dy);
      p_sdx <= 28'(sin_l) * 28'(dx);
      p_cdy <= 28'(cos_l) * 28'(dy);
    end
  end

  always_comb begin
    sum_x = 29'(p_cdx) + 29'(p_sdy) + 29'sd8192;
    sum_y = 29'(p_cdy) - 29'(p_sdx) + 29'sd8192;
    sx    = 16'(sum_x >>> FRAC_BITS) + 16'(CX);
    sy    = 16'(sum_y >>> FRAC_BITS) + 16'(CY);
  end

endmodule

// File: rtl/vram_rot_fetch.sv
// Rotated ZBT read-address generator and pixel fetcher, fixed latency 4+ZBT_LAT.
// Optional build macro ROT_CHECKER_EN: out-of-image pixels show a checkerboard.
module vram_rot_fetch
  import vram_pkg::*;
#(
  parameter int          CX       = 400,
  parameter int          CY       = 300,
  parameter int unsigned ZBT_LAT  = 2,
  parameter pixel_t      BG_COLOR = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic signed [15:0] cos_q,
  input  logic signed [15:0] sin_q,
  vram_rot_fetch_if.master   vram,
  output pixel_t             pixel,
  output logic               pix_valid,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out
);

  localparam int unsigned DLY = 3 + ZBT_LAT;
  localparam logic [10:0]        H_LIM  = 11'(H_ACTIVE);
  localparam logic [9:0]         V_LIM  = 10'(V_ACTIVE);
  localparam logic signed [15:0] SX_LIM = 16'(H_ACTIVE);
  localparam logic signed [15:0] SY_LIM = 16'(V_ACTIVE);

  logic signed [15:0] cos_l, sin_l;
  logic signed [11:0] dx, dy, dx_d, dy_d;
  logic [DLY-1:0]     act_pipe;
  logic [ZBT_LAT:0]   oob_pipe;
  logic [10:0]        hc_pipe [DLY];
  logic [9:0]         vc_pipe [DLY];

  logic               act_in, oob_s2;
  logic signed [15:0] sx, sy;
  vaddr_t             addr_s2;
  pixel_t             oob_pix;
  logic               unused_bits;

  assign act_in  = en && (hcount < H_LIM) && (vcount < V_LIM);
  assign dx_d    = $signed({1'b0, hcount}) - 12'(CX);
  assign dy_d    = $signed({2'b0, vcount}) - 12'(CY);
  assign oob_s2  = sx[15] || (sx >= SX_LIM) || sy[15] || (sy >= SY_LIM);
  assign addr_s2 = row_addr(sy[9:0], sx[10:0]);
  assign unused_bits = ^{vram.vram_read_data[35:16], sx[15:11], sy[15:10]};

  rot_mac #(
    .CX (CX),
    .CY (CY)
  ) u_rot_mac (
    .clk   (clk),
    .reset (reset),
    .cos_l (cos_l),
    .sin_l (sin_l),
    .dx    (dx),
    .dy    (dy),
    .sx    (sx),
    .sy    (sy)
  );

  always_comb begin
`ifdef ROT_CHECKER_EN
    oob_pix = (hc_pipe[DLY-1][4] ^ vc_pipe[DLY-1][4]) ? 16'h8410 : 16'h0000;
`else
    oob_pix = BG_COLOR;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cos_l          <= ONE;
      sin_l          <= '0;
      dx             <= '0;
      dy             <= '0;
      act_pipe       <= '0;
      oob_pipe       <= '0;
      for (int i = 0; i < DLY; i++) begin
        hc_pipe[i] <= '0;
        vc_pipe[i] <= '0;
      end
      vram.vram_addr <= '0;
      pixel          <= '0;
      pix_valid      <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      // Angle only moves at the top-left pixel so a frame is never torn.
      if (hcount == 11'd0 && vcount == 10'd0) begin
        cos_l <= cos_q;
        sin_l <= sin_q;
      end
      dx          <= dx_d;
      dy          <= dy_d;
      act_pipe[0] <= act_in;
      hc_pipe[0]  <= hcount;
      vc_pipe[0]  <= vcount;
      for (int i = 1; i < DLY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hc_pipe[i]  <= hc_pipe[i-1];
        vc_pipe[i]  <= vc_pipe[i-1];
      end
      oob_pipe[0] <= oob_s2;
      for (int i = 1; i <= ZBT_LAT; i++) oob_pipe[i] <= oob_pipe[i-1];
      if (act_pipe[1] && !oob_s2) vram.vram_addr <= addr_s2;

      pix_valid  <= act_pipe[DLY-1];
      hcount_out <= hc_pipe[DLY-1];
      vcount_out <= vc_pipe[DLY-1];
      if (!act_pipe[DLY-1])       pixel <= '0;
      else if (oob_pipe[ZBT_LAT]) pixel <= oob_pix;
      else                        pixel <= vram.vram_read_data[15:0];
    end
  end

endmodule
